// File: rtl/uart_tx_frame.sv
// UART transmitter. Each frame is a start bit, DATA_WIDTH data bits, an optional parity bit and 1-2 stop bits.
// Each serial bit is held for CLKS_PER_BIT clocks. Input uses a ready/valid handshake, and frames can run back-to-back.
module uart_tx_frame #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  valid,
    output logic                  ready,
    output logic                  tx,
    output logic                  busy
);

    // state    | meaning
    // S_IDLE   | line high, waiting for a word
    // S_START  | start bit (0)
    // S_DATA   | payload bits, idx_q selects the bit
    // S_PARITY | parity bit (never entered when PARITY=0)
    // S_STOP   | stop bit(s) (1), idx_q counts them
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 2);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  bit_last;
    logic                  frame_end;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tx_d      = tx_q;
        bit_last  = (cnt_q == CNT_LAST);
        frame_end = (state_q == S_STOP) && bit_last && (idx_q == STOP_LAST);
        ready     = (state_q == S_IDLE) || frame_end;

        if (state_q != S_IDLE) begin
            cnt_d = bit_last ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
            end
            S_START: begin
                if (bit_last) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = (MSB_FIRST != 0) ? shift_q[DATA_WIDTH-1] : shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_last) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                        // The outgoing bit always sits at the shift register's send end.
                        if (MSB_FIRST != 0) begin
                            shift_d = shift_q << 1;
                            tx_d    = shift_d[DATA_WIDTH-1];
                        end else begin
                            shift_d = shift_q >> 1;
                            tx_d    = shift_d[0];
                        end
                    end
                end
            end
            S_PARITY: begin
                if (bit_last) begin
                    state_d = S_STOP;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_last) begin
                    if (idx_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // An accept takes priority, so the next start bit directly follows the last stop clock.
        if (valid && ready) begin
            state_d = S_START;
            cnt_d   = '0;
            idx_d   = '0;
            shift_d = data;
            par_d   = (^data) ^ PAR_ODD;
            tx_d    = 1'b0;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != S_IDLE);

endmodule
